// File: rtl/demux_gather_4_if.sv
// Bus bundle for the 4-lane register link receiver: the beat input side
// (valid/ready, lane tag, chunk) and the frame output side (valid/ready,
// packed frame, overrun pulse).
interface demux_gather_4_if #(
    parameter int NUM_REGISTERS_PER = 4,
    parameter int WIDTH_REGISTER    = 4
);
    localparam int WIDTH = NUM_REGISTERS_PER * WIDTH_REGISTER;

    logic                      in_valid;
    logic                      in_ready;
    logic [1:0]                in_lane;
    logic [WIDTH_REGISTER-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [4*WIDTH-1:0]        outp;
    logic                      err_overrun;

    // Transmitter / consumer view
    modport master (
        output in_valid, in_lane, in_data, out_ready,
        input  in_ready, out_valid, outp, err_overrun
    );

    // Receiver (gather block) view
    modport slave (
        input  in_valid, in_lane, in_data, out_ready,
        output in_ready, out_valid, outp, err_overrun
    );
endinterface

// File: rtl/demux_gather_4.sv
// Receive end of the time-multiplexed 4-lane register link. Chunks tagged
// with a lane are placed into an assembly buffer; once every lane word is
// complete the buffer is moved into the output register, so one frame can
// be assembled while the previous one waits for the consumer.
module demux_gather_4 #(
    parameter int NUM_REGISTERS_PER = 4,
    parameter int WIDTH_REGISTER    = 4
) (
    input logic              clk,
    input logic              rst,
    demux_gather_4_if.slave  bus
);
    localparam int WIDTH      = NUM_REGISTERS_PER * WIDTH_REGISTER;
    localparam int NUM_CHUNKS = 4 * NUM_REGISTERS_PER;
    localparam int CW         = $clog2(NUM_REGISTERS_PER);

    // Assembly buffer as a chunk array: chunk index {lane, cnt} lands at
    // bit offset (lane*NUM_REGISTERS_PER + cnt)*WIDTH_REGISTER, chunk 0 = LSB.
    logic [NUM_CHUNKS-1:0][WIDTH_REGISTER-1:0] asm_r;
    logic [3:0][CW-1:0]                        cnt_r;
    logic [3:0]                                done_r;
    logic                                      asm_full_r;
    logic                                      out_valid_r;
    logic [4*WIDTH-1:0]                        outp_r;
    logic                                      err_r;

    logic [3:0]    lane_mask_s;
    logic [CW-1:0] cur_cnt_s;
    logic [CW+1:0] chunk_idx_s;
    logic          in_ready_s;
    logic          accept_s;
    logic          write_s;
    logic          overrun_s;
    logic          last_chunk_s;
    logic          completing_s;
    logic          out_free_s;
    logic          transfer_s;
    logic          drain_s;

    // Beat decode, acceptance, overrun detection and transfer decision
    always_comb begin
        lane_mask_s  = 4'b0001 << bus.in_lane;
        cur_cnt_s    = cnt_r[bus.in_lane];
        chunk_idx_s  = {bus.in_lane, cur_cnt_s};
        // in_ready depends only on state and reset, never on in_valid/out_ready
        in_ready_s   = rst & ~asm_full_r;
        accept_s     = bus.in_valid & in_ready_s;
        overrun_s    = 1'b0;
        write_s      = 1'b0;
        if (accept_s) begin
            overrun_s = ((done_r & lane_mask_s) != 4'b0000);
            write_s   = ~overrun_s;
        end else begin
            overrun_s = 1'b0;
            write_s   = 1'b0;
        end
        last_chunk_s = (cur_cnt_s == CW'(NUM_REGISTERS_PER - 1));
        completing_s = write_s & last_chunk_s & ((done_r | lane_mask_s) == 4'b1111);
        out_free_s   = ~out_valid_r | bus.out_ready;
        transfer_s   = asm_full_r & out_free_s;
        drain_s      = out_valid_r & bus.out_ready;
    end

    // Assembly buffer, per-lane chunk counters and lane-complete flags.
    // A write can never coincide with a transfer: writes need !asm_full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_r      <= '0;
            cnt_r      <= '0;
            done_r     <= 4'b0000;
            asm_full_r <= 1'b0;
        end else if (transfer_s) begin
            cnt_r      <= '0;
            done_r     <= 4'b0000;
            asm_full_r <= 1'b0;
        end else if (write_s) begin
            asm_r[chunk_idx_s]   <= bus.in_data;
            cnt_r[bus.in_lane]   <= cur_cnt_s + CW'(1'b1);
            if (last_chunk_s) begin
                done_r <= done_r | lane_mask_s;
            end else begin
                done_r <= done_r;
            end
            asm_full_r <= completing_s;
        end else begin
            asm_full_r <= asm_full_r;
        end
    end

    // Output frame register: load on transfer, release on handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            outp_r      <= '0;
        end else if (transfer_s) begin
            out_valid_r <= 1'b1;
            outp_r      <= asm_r;
        end else if (drain_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Overrun pulse: one cycle after a beat aimed at an already complete lane
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= overrun_s;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.outp        = outp_r;
    assign bus.err_overrun = err_r;

endmodule

// File: tb/tb_demux_gather_4.sv
// Self-checking bench for demux_gather_4: expected frames are queued when a
// frame is driven and compared when the DUT hands a frame to the consumer.
module tb_demux_gather_4;
    localparam int NRP = 4;
    localparam int WR  = 4;
    localparam int LIM = 200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_cnt  = 0;
    logic [63:0] exp_q[$];

    logic [3:0][15:0] f1, f2, f3, f4, fr;

    demux_gather_4_if #(.NUM_REGISTERS_PER(NRP), .WIDTH_REGISTER(WR)) bus();

    demux_gather_4 #(.NUM_REGISTERS_PER(NRP), .WIDTH_REGISTER(WR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Consumer-side scoreboard and overrun pulse counter
    always @(negedge clk) begin : mon
        logic [63:0] e;
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("frame", bus.outp, e);
            end
        end
        if (rst && bus.err_overrun) err_cnt++;
    end

    // Caller is just after a posedge; returns just after the accepting posedge
    task automatic send(input logic [1:0] lane, input logic [3:0] d);
        int g;
        g = 0;
        bus.in_valid = 1'b1;
        bus.in_lane  = lane;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && g < LIM) begin
            @(negedge clk);
            g++;
        end
        if (g >= LIM) check("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0][15:0] w, input bit lane_seq);
        exp_q.push_back(w);
        if (!lane_seq) begin
            for (int k = 0; k < 4; k++)
                for (int l = 0; l < 4; l++)
                    send(2'(l), w[l][k*4 +: 4]);
        end else begin
            for (int l = 3; l >= 0; l--)
                for (int k = 0; k < 4; k++)
                    send(2'(l), w[l][k*4 +: 4]);
        end
    endtask

    task automatic wait_empty();
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < LIM) begin
            @(negedge clk);
            g++;
        end
        check("queue_drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        f1 = {16'h137F, 16'h1248, 16'hF731, 16'h8421};
        f2 = {16'hF0F0, 16'h0F0F, 16'h5555, 16'hAAAA};
        f3 = {16'h0C3A, 16'h9E61, 16'h47B2, 16'h8421};
        f4 = {16'h1357, 16'h2468, 16'h9ABC, 16'hFEDC};
        fr = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        bus.in_valid  = 1'b0;
        bus.in_lane   = 2'd0;
        bus.in_data   = 4'h0;
        bus.out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_outp", bus.outp, 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_err", 64'(bus.err_overrun), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        // 1: round-robin, latency and one-cycle valid pulse
        bus.out_ready = 1'b1;
        send_frame(f1, 1'b0);
        @(negedge clk);
        check("lat_edge_e", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("lat_edge_e1", 64'(bus.out_valid), 64'd1);
        check("rr_outp", bus.outp, 64'h137F_1248_F731_8421);
        @(negedge clk);
        check("valid_pulse", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;

        // 2: lane-sequential order gives the identical frame
        send_frame(f1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("seq_outp", bus.outp, 64'h137F_1248_F731_8421);
        @(posedge clk); #1;
        wait_empty();

        // 3 + 6: backpressure with two frames, then drain-and-load
        bus.out_ready = 1'b0;
        send_frame(f1, 1'b0);
        send_frame(f2, 1'b0);
        @(negedge clk);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_valid", 64'(bus.out_valid), 64'd1);
        check("bp_hold_f1", bus.outp, 64'h137F_1248_F731_8421);
        repeat (3) @(negedge clk);
        check("bp_in_ready_hold", 64'(bus.in_ready), 64'd0);
        check("bp_hold_f1_late", bus.outp, 64'h137F_1248_F731_8421);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("dl_valid_stays", 64'(bus.out_valid), 64'd1);
        check("dl_outp_f2", bus.outp, 64'hF0F0_0F0F_5555_AAAA);
        @(negedge clk);
        check("bp_valid_done", 64'(bus.out_valid), 64'd0);
        check("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        wait_empty();

        // 4: overrun on lane 0 (back-to-back), lane 0 word untouched
        err_cnt = 0;
        exp_q.push_back(f3);
        for (int k = 0; k < 4; k++) send(2'd0, f3[0][k*4 +: 4]);
        send(2'd0, 4'hF);
        send(2'd0, 4'hE);
        @(negedge clk);
        check("overrun_pulse", 64'(bus.err_overrun), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("overrun_end", 64'(bus.err_overrun), 64'd0);
        check("overrun_count", 64'(err_cnt), 64'd2);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++)
            for (int l = 1; l < 4; l++)
                send(2'(l), f3[l][k*4 +: 4]);
        wait_empty();
        check("overrun_lane0", bus.outp[15:0], 64'h8421);

        // 5: reset mid-frame, then a clean frame
        for (int i = 0; i < 9; i++) send(2'(i % 4), fr[i % 4][(i / 4)*4 +: 4]);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_outp", bus.outp, 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("mid_rst_in_ready2", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        send_frame(f4, 1'b0);
        wait_empty();
        check("fresh_outp", bus.outp, 64'h1357_2468_9ABC_FEDC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
